// File: rtl/scan_area_accum.sv
// Per-frame accumulator of clamped, saturated surface-area samples with a valid/ready readout.
// Optional running-peak output enabled by defining SCAN_AREA_ACCUM_PEAK_EN.
module scan_area_accum #(
  parameter int unsigned SEG_COUNT = 360,
  parameter int unsigned SUM_W     = 42
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [25:0] area_in,
  input  logic               area_vld,
  output logic [SUM_W-1:0]   sum_out,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [15:0]        seg_cnt,
  output logic               busy,
  output logic               ovf,
  output logic               neg,
  output logic               drop
`ifdef SCAN_AREA_ACCUM_PEAK_EN
  ,
  output logic [24:0]        peak_out
`endif
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  localparam logic [15:0]      SegLast = 16'(SEG_COUNT);
  localparam logic [SUM_W-1:0] SumMax  = '1;

  state_e           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] sum_out_q, sum_out_d;
  logic             sum_valid_q, sum_valid_d;
  logic [15:0]      seg_cnt_q, seg_cnt_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic             drop_q, drop_d;

  logic             sample_neg;
  logic [24:0]      contrib;
  logic [SUM_W:0]   sum_ext;
  logic [SUM_W-1:0] sat_sum;
  logic             sat_ovf;
  logic             accept, last, handshake, clear;

  // Negative samples contribute zero; the carry bit of sum_ext flags saturation.
  assign sample_neg = area_in[25];
  assign contrib    = sample_neg ? '0 : area_in[24:0];
  assign sum_ext    = {1'b0, acc_q} + {{(SUM_W - 24){1'b0}}, contrib};
  assign sat_ovf    = sum_ext[SUM_W];
  assign sat_sum    = sat_ovf ? SumMax : sum_ext[SUM_W-1:0];

  // start in ACCUM wins over a coincident sample; start in HOLD needs the handshake.
  assign handshake = (state_q == StHold) && sum_ready;
  assign accept    = (state_q == StAccum) && area_vld && !start;
  assign last      = accept && ((seg_cnt_q + 16'd1) == SegLast);
  assign clear     = start && ((state_q == StIdle) || (state_q == StAccum) || handshake);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StAccum;
      StAccum: if (last) state_d = StHold;
      StHold:  if (handshake) state_d = start ? StAccum : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    sum_out_d   = sum_out_q;
    sum_valid_d = sum_valid_q;
    seg_cnt_d   = seg_cnt_q;
    ovf_d       = ovf_q;
    neg_d       = neg_q;
    drop_d      = area_vld && (state_q != StAccum);
    if (clear) begin
      acc_d     = '0;
      seg_cnt_d = '0;
      ovf_d     = 1'b0;
      neg_d     = 1'b0;
    end else if (accept) begin
      acc_d     = sat_sum;
      seg_cnt_d = seg_cnt_q + 16'd1;
      ovf_d     = ovf_q | sat_ovf;
      neg_d     = neg_q | sample_neg;
      if (last) begin
        sum_out_d   = sat_sum;
        sum_valid_d = 1'b1;
      end
    end
    if (handshake) sum_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      seg_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      neg_q       <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      seg_cnt_q   <= seg_cnt_d;
      ovf_q       <= ovf_d;
      neg_q       <= neg_d;
      drop_q      <= drop_d;
    end
  end

`ifdef SCAN_AREA_ACCUM_PEAK_EN
  logic [24:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clear) begin
      peak_d = '0;
    end else if (accept && (contrib > peak_q)) begin
      peak_d = contrib;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_out = peak_q;
`endif

  always_comb begin
    busy      = (state_q == StAccum);
    sum_out   = sum_out_q;
    sum_valid = sum_valid_q;
    seg_cnt   = seg_cnt_q;
    ovf       = ovf_q;
    neg       = neg_q;
    drop      = drop_q;
  end

endmodule

// File: tb/tb_scan_area_accum.sv
// Directed plus randomized bench for scan_area_accum (SEG_COUNT=4, SUM_W=26).
// Expected frame totals come from a whole-frame arithmetic model.
module tb_scan_area_accum;

  localparam int unsigned SegCount = 4;
  localparam int unsigned SumW     = 26;
  localparam longint      SumMax   = (longint'(1) << SumW) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic signed [25:0] area_in;
  logic               area_vld;
  logic [SumW-1:0]    sum_out;
  logic               sum_valid;
  logic               sum_ready;
  logic [15:0]        seg_cnt;
  logic               busy;
  logic               ovf;
  logic               neg;
  logic               drop;
`ifdef SCAN_AREA_ACCUM_PEAK_EN
  logic [24:0]        peak_out;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  scan_area_accum #(
    .SEG_COUNT(SegCount),
    .SUM_W    (SumW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .area_in  (area_in),
    .area_vld (area_vld),
    .sum_out  (sum_out),
    .sum_valid(sum_valid),
    .sum_ready(sum_ready),
    .seg_cnt  (seg_cnt),
    .busy     (busy),
    .ovf      (ovf),
    .neg      (neg),
    .drop     (drop)
`ifdef SCAN_AREA_ACCUM_PEAK_EN
    ,
    .peak_out (peak_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Whole-frame model: clamp negatives to zero, add, saturate the total.
  function automatic void model(input int s[4], output longint sum, output bit o, output bit n);
    longint t = 0;
    n = 1'b0;
    foreach (s[i]) begin
      if (s[i] < 0) n = 1'b1;
      else t += s[i];
    end
    o   = (t > SumMax);
    sum = o ? SumMax : t;
  endfunction

  function automatic int rnd_sample();
    case ($urandom_range(0, 3))
      0:       return -int'($urandom_range(1, 1 << 25));
      1:       return int'($urandom_range((1 << 25) - 1000, (1 << 25) - 1));
      default: return int'($urandom_range(0, 5000000));
    endcase
  endfunction

  task automatic run_frame(input int s[4], input bit do_start, input bit gaps);
    if (do_start) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      area_vld = 1'b1;
      area_in  = 26'(s[i]);
      step();
      area_vld = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input int s[4]);
    longint es;
    bit     eo, en;
    model(s, es, eo, en);
    chk({tag, ".valid"}, 64'(sum_valid), 64'd1);
    chk({tag, ".sum"}, 64'(sum_out), 64'(es));
    chk({tag, ".cnt"}, 64'(seg_cnt), 64'(SegCount));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".neg"}, 64'(neg), 64'(en));
    chk({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".sum"}, 64'(sum_out), 64'd0);
    chk({tag, ".valid"}, 64'(sum_valid), 64'd0);
    chk({tag, ".cnt"}, 64'(seg_cnt), 64'd0);
    chk({tag, ".busy"}, 64'(busy), 64'd0);
    chk({tag, ".ovf"}, 64'(ovf), 64'd0);
    chk({tag, ".neg"}, 64'(neg), 64'd0);
    chk({tag, ".drop"}, 64'(drop), 64'd0);
  endtask

  initial begin
    int     s[4];
    longint held;
    rst_n     = 1'b0;
    start     = 1'b0;
    area_vld  = 1'b0;
    area_in   = '0;
    sum_ready = 1'b1;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Nominal frame, consumer ready: one valid cycle then back to IDLE.
    s = '{100, 200, 300, 400};
    run_frame(s, 1'b1, 1'b0);
    check_frame("nominal", s);
    step();
    chk("nominal.valid_drop", 64'(sum_valid), 64'd0);
    chk("nominal.idle", 64'(busy), 64'd0);

    s = '{50, -7, 50, 50};
    run_frame(s, 1'b1, 1'b0);
    check_frame("negclamp", s);
    step();

    s = '{(1 << 25) - 1, (1 << 25) - 1, (1 << 25) - 1, (1 << 25) - 1};
    run_frame(s, 1'b1, 1'b0);
    check_frame("saturate", s);
    step();

    // Stall in HOLD: samples are dropped, start is ignored, sum is frozen.
    sum_ready = 1'b0;
    s = '{rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()};
    run_frame(s, 1'b1, 1'b0);
    check_frame("stall", s);
    held = longint'(sum_out);
    for (int c = 0; c < 10; c++) begin
      area_vld = (c % 2 == 0);
      area_in  = 26'(rnd_sample());
      start    = (c % 3 == 0);
      step();
      area_vld = 1'b0;
      start    = 1'b0;
      chk("stall.drop", 64'(drop), 64'(c % 2 == 0));
      chk("stall.hold_sum", 64'(sum_out), 64'(held));
      chk("stall.hold_valid", 64'(sum_valid), 64'd1);
    end
    sum_ready = 1'b1;
    step();
    chk("stall.handshake", 64'(sum_valid), 64'd0);
    step();
    chk("stall.single", 64'(sum_valid), 64'd0);
    chk("stall.idle", 64'(busy), 64'd0);

    // Abort: restart after two samples, coincident sample discarded without drop.
    start = 1'b1;
    step();
    start    = 1'b0;
    area_vld = 1'b1;
    area_in  = 26'sd10;
    step();
    area_in = 26'sd20;
    step();
    start   = 1'b1;
    area_in = 26'sd999;
    step();
    start    = 1'b0;
    area_vld = 1'b0;
    chk("abort.drop", 64'(drop), 64'd0);
    chk("abort.cnt", 64'(seg_cnt), 64'd0);
    chk("abort.busy", 64'(busy), 64'd1);
    s = '{5, 5, 5, 5};
    run_frame(s, 1'b0, 1'b0);
    check_frame("abort", s);
    step();

    // Drop from IDLE.
    area_vld = 1'b1;
    area_in  = 26'sd77;
    step();
    area_vld = 1'b0;
    chk("idle.drop", 64'(drop), 64'd1);
    step();
    chk("idle.drop_end", 64'(drop), 64'd0);

`ifdef SCAN_AREA_ACCUM_PEAK_EN
    s = '{3, 900, 12, 7};
    run_frame(s, 1'b1, 1'b0);
    check_frame("peak", s);
    chk("peak.value", 64'(peak_out), 64'd900);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("peak.clear", 64'(peak_out), 64'd0);
    run_frame('{1, 2, 3, 4}, 1'b0, 1'b0);
    step();
`endif

    // Randomized frames with gaps between samples.
    for (int f = 0; f < 20; f++) begin
      s = '{rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample()};
      run_frame(s, 1'b1, 1'b1);
      check_frame("random", s);
      step();
      chk("random.done", 64'(sum_valid), 64'd0);
    end

    // Asynchronous reset while holding a result.
    sum_ready = 1'b0;
    s = '{1000, 2000, 3000, 4000};
    run_frame(s, 1'b1, 1'b0);
    check_frame("prerst", s);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    rst_n     = 1'b1;
    sum_ready = 1'b1;
    step();
    check_all_zero("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
